// File: rtl/duty_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : duty_disp_pkg
// Description : Shared types and constants for the duty-cycle display path:
//               converter FSM states, BCD digit width and the double-dabble
//               add-3 threshold.
// Revision    : 1.0 - initial release
// ============================================================================
package duty_disp_pkg;

  // Width of one packed BCD digit
  localparam int unsigned BCD_W = 4;

  // A BCD digit at or above this value is corrected by adding 3 before a shift
  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

  // Converter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

endpackage : duty_disp_pkg
`default_nettype wire

// File: rtl/bcd_add3_cell.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3_cell
// Description : Double-dabble correction cell. A BCD digit of 5 or more gets 3
//               added so that the following left shift carries correctly into
//               the next decimal position.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_cell
  import duty_disp_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  // Digits 0..9 only ever reach this cell, so digit+3 never exceeds 4 bits
  assign digit_o = (digit_i >= ADD3_THRESH) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_add3_cell
`default_nettype wire

// File: rtl/duty_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : duty_bcd_converter
// Description : Iterative binary-to-BCD converter (shift-and-add-3, one bit
//               per clock) feeding the seven-segment decoders. Produces one
//               BCD digit per display position plus a leading-zero blank mask.
//               Outputs are registered and held between conversions.
// Revision    : 1.0 - initial release
// ============================================================================
module duty_bcd_converter
  import duty_disp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]       blank
);

  localparam int                 CNT_W     = $clog2(WIDTH + 1);
  localparam int                 SCR_W     = BCD_W * DIGITS;
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(1);
  localparam logic [DIGITS-1:0]  BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  if ((WIDTH < 4) || (WIDTH > 16)) begin : g_bad_width
    $error("duty_bcd_converter: WIDTH must be within 4..16");
  end

  if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_bad_digits
    $error("duty_bcd_converter: DIGITS too small to hold 2^WIDTH-1 in decimal");
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  conv_state_t            state_q,   state_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [WIDTH-1:0]       shreg_q,   shreg_d;
  logic [SCR_W-1:0]       scratch_q, scratch_d;

  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic [SCR_W-1:0]       digits_q,  digits_d;
  logic [DIGITS-1:0]      blank_q,   blank_d;

  logic [SCR_W-1:0]       scratch_adj;
  logic [SCR_W+WIDTH-1:0] shift_w;
  logic [DIGITS-1:0]      blank_w;
  logic                   zeros_above;

  // --------------------------------------------------------------------------
  // One add-3 correction cell per digit, all evaluated in parallel
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3_cell u_add3 (
      .digit_i (scratch_q[BCD_W*k +: BCD_W]),
      .digit_o (scratch_adj[BCD_W*k +: BCD_W])
    );
  end

  // The top scratch bit shifted out is always 0 because DIGITS is large
  // enough to represent every WIDTH-bit value.
  assign shift_w = {scratch_adj, shreg_q} << 1;

  // Leading-zero mask: digit k blanks only if it and every digit above it are 0
  always_comb begin
    blank_w     = '0;
    zeros_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zeros_above = zeros_above && (scratch_q[BCD_W*k +: BCD_W] == '0);
      blank_w[k]  = zeros_above;
    end
  end

  // Next-state logic: accept in IDLE, shift WIDTH times, then one DONE cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          shreg_d   = value;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
        end
      end
      ST_SHIFT: begin
        {scratch_d, shreg_d} = shift_w;
        cnt_d                = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next-state for the registered outputs; digits/blank load only from DONE
  always_comb begin
    busy_d   = (state_d != ST_IDLE) || (state_q == ST_DONE);
    done_d   = (state_q == ST_DONE);
    digits_d = digits_q;
    blank_d  = blank_q;
    if (state_q == ST_DONE) begin
      digits_d = scratch_q;
      blank_d  = blank_w;
    end
  end

  // FSM and conversion datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
    end
  end

  // Output registers; a reset mid-conversion clears them without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= '0;
      blank_q  <= BLANK_RST;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign digits = digits_q;
  assign blank  = blank_q;

endmodule : duty_bcd_converter
`default_nettype wire

// File: tb/tb_duty_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_duty_bcd_converter
// Description : Self-checking bench for duty_bcd_converter (WIDTH=8,
//               DIGITS=3). Drivers push expected digits/blank/done-cycle into
//               a scoreboard; a monitor pops and compares on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  value;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0] blank;

  typedef struct {
    logic [11:0] dig;
    logic [2:0]  blk;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  duty_bcd_converter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .value  (value),
    .busy   (busy),
    .done   (done),
    .digits (digits),
    .blank  (blank)
  );

  always #5 clk = ~clk;

  // Edge counter: sampled after edge n it reads n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] blank_of(input int v);
    return {(v < 100), (v < 10), 1'b0};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_without_request", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("digits", 32'(digits), 32'(e.dig));
        check("blank", 32'(blank), 32'(e.blk));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0) begin
      n++;
      if (n > 50) begin
        check("idle_timeout", 32'(busy), 32'd0);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Issue one conversion from IDLE; t returns the accepting edge index
  task automatic convert(input logic [7:0] v, input logic [11:0] d,
                         input logic [2:0] b, output int t);
    wait_idle();
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    t     = cyc;
    start = 1'b0;
    sb.push_back('{dig: d, blk: b, cyc: t + 9});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t0;
    int n;
    int tmp;
    int j;
    int perm[256];

    rst   = 1'b1;
    start = 1'b0;
    value = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
    end
    check("rst_digits", 32'(digits), 32'h000);
    check("rst_blank", 32'(blank), 32'b110);
    check("rst_busy", 32'(busy), 32'd0);

    // 255: latency and busy window
    convert(8'd255, 12'h255, 3'b000, t);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_window", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("digits_hold", 32'(digits), 32'h255);

    // Short sequence covering blanking
    convert(8'd100, 12'h100, 3'b000, t);
    convert(8'd9,   12'h009, 3'b110, t);
    convert(8'd0,   12'h000, 3'b110, t);

    // Re-pulsed start during SHIFT must be dropped
    convert(8'd200, 12'h200, 3'b000, t);
    repeat (2) @(posedge clk);
    #1;
    value = 8'd42;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 8'd0;
    repeat (20) @(negedge clk);
    check("single_done", sb.size(), 0);
    check("digits_after_drop", 32'(digits), 32'h200);

    // Reset during the 4th SHIFT cycle of 137
    wait_idle();
    value = 8'd137;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_digits", 32'(digits), 32'h000);
    check("abort_blank", 32'(blank), 32'b110);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (15) @(negedge clk);
    convert(8'd137, 12'h137, 3'b000, t);

    // Start held high: shuffled sweep of 0..255, accepts every 10 cycles
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    wait_idle();
    value = 8'(perm[0]);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    sb.push_back('{dig: bcd_of(perm[0]), blk: blank_of(perm[0]), cyc: t0 + 9});
    for (int i = 1; i < 256; i++) begin
      value = 8'(perm[i]);
      repeat (10) @(posedge clk);
      #1;
      sb.push_back('{dig: bcd_of(perm[i]), blk: blank_of(perm[i]), cyc: t0 + 10 * i + 9});
    end
    start = 1'b0;

    // Drain the scoreboard with a bounded wait
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_duty_bcd_converter
`default_nettype wire
